alu_mc: RTL

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc_if.sv | 26 ++
 rtl/alu_mc.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_mc_if.sv
// Request/response bundle for the multi-cycle ALU: operand request channel
// plus result channel with valid/ready flow control on both sides.
interface alu_mc_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic [3:0]       select;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_y;
  logic             flag_zero;
  logic             flag_dz;

  modport master (
    output in_valid, data_a, data_b, select, out_ready,
    input  in_ready, out_valid, result_y, flag_zero, flag_dz
  );

  modport slave (
    input  in_valid, data_a, data_b, select, out_ready,
    output in_ready, out_valid, result_y, flag_zero, flag_dz
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops register their result directly, signed
// divide/remainder run a WIDTH-step restoring divider on operand magnitudes.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input logic    clk,
  input logic    rst,
  alu_mc_if.slave bus
);
  localparam int unsigned SW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             accept_c;
  logic             is_div_c;
  logic             last_c;
  logic [SW-1:0]    shamt_c;
  logic [WIDTH-1:0] alu_c;
  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;
  logic [WIDTH:0]   rem_sh_c;
  logic [WIDTH-1:0] rem_nxt_c;
  logic [WIDTH-1:0] quot_nxt_c;
  logic             qbit_c;
  logic [WIDTH-1:0] div_res_c;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quot_q;
  logic [SW-1:0]    cnt_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic             is_rem_q;
  logic             dz_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             flag_zero_q;
  logic             flag_dz_q;

  assign bus.in_ready  = !rst && (state == IDLE || (state == DONE && bus.out_ready));
  assign bus.out_valid = out_valid_q;
  assign bus.result_y  = result_q;
  assign bus.flag_zero = flag_zero_q;
  assign bus.flag_dz   = flag_dz_q;

  assign accept_c = bus.in_valid && bus.in_ready;
  assign is_div_c = (bus.select[3:1] == 3'b111);
  assign last_c   = (cnt_q == SW'(WIDTH - 1));
  assign shamt_c  = bus.data_b[SW-1:0];
  assign mag_a_c  = bus.data_a[WIDTH-1] ? WIDTH'(-bus.data_a) : bus.data_a;
  assign mag_b_c  = bus.data_b[WIDTH-1] ? WIDTH'(-bus.data_b) : bus.data_b;

  // Single-cycle operations, evaluated on the live request operands
  always_comb begin
    alu_c = '0;
    case (bus.select)
      4'd0:    alu_c = bus.data_a + bus.data_b;
      4'd1:    alu_c = bus.data_a - bus.data_b;
      4'd2:    alu_c = bus.data_a * bus.data_b;
      4'd3:    alu_c = bus.data_a & bus.data_b;
      4'd4:    alu_c = bus.data_a | bus.data_b;
      4'd5:    alu_c = bus.data_a ^ bus.data_b;
      4'd6:    alu_c = ~bus.data_a;
      4'd7:    alu_c = bus.data_a << shamt_c;
      4'd8:    alu_c = bus.data_a >> shamt_c;
      4'd9:    alu_c = WIDTH'($signed(bus.data_a) >>> shamt_c);
      4'd10:   alu_c = WIDTH'($signed(bus.data_a) < $signed(bus.data_b));
      4'd11:   alu_c = WIDTH'(bus.data_a < bus.data_b);
      4'd12:   alu_c = WIDTH'(bus.data_a == bus.data_b);
      4'd13:   alu_c = bus.data_b;
      default: alu_c = '0;
    endcase
  end

  // One restoring shift-subtract step plus final sign correction
  always_comb begin
    rem_sh_c  = {rem_q, quot_q[WIDTH-1]};
    qbit_c    = 1'b0;
    rem_nxt_c = rem_sh_c[WIDTH-1:0];
    if (rem_sh_c >= {1'b0, dvs_q}) begin
      qbit_c    = 1'b1;
      rem_nxt_c = WIDTH'(rem_sh_c - {1'b0, dvs_q});
    end
    quot_nxt_c = {quot_q[WIDTH-2:0], qbit_c};
    if (dz_q)
      div_res_c = is_rem_q ? a_q : '1;
    else if (is_rem_q)
      div_res_c = neg_r_q ? WIDTH'(-rem_nxt_c) : rem_nxt_c;
    else
      div_res_c = neg_q_q ? WIDTH'(-quot_nxt_c) : quot_nxt_c;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept_c) state_nxt = is_div_c ? DIV : DONE;
      DIV:  if (last_c) state_nxt = DONE;
      DONE: begin
        if (accept_c)           state_nxt = is_div_c ? DIV : DONE;
        else if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand capture, divider iteration and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flag_zero_q <= 1'b0;
      flag_dz_q   <= 1'b0;
      a_q         <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      cnt_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      is_rem_q    <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      out_valid_q <= (state_nxt == DONE);
      if (accept_c) begin
        if (is_div_c) begin
          a_q      <= bus.data_a;
          dvs_q    <= mag_b_c;
          quot_q   <= mag_a_c;
          rem_q    <= '0;
          cnt_q    <= '0;
          neg_q_q  <= bus.data_a[WIDTH-1] ^ bus.data_b[WIDTH-1];
          neg_r_q  <= bus.data_a[WIDTH-1];
          is_rem_q <= bus.select[0];
          dz_q     <= (bus.data_b == '0);
        end else begin
          result_q    <= alu_c;
          flag_zero_q <= (alu_c == '0);
          flag_dz_q   <= 1'b0;
        end
      end else if (state == DIV) begin
        rem_q  <= rem_nxt_c;
        quot_q <= quot_nxt_c;
        cnt_q  <= cnt_q + SW'(1);
        if (last_c) begin
          result_q    <= div_res_c;
          flag_zero_q <= (div_res_c == '0);
          flag_dz_q   <= dz_q;
        end
      end
    end
  end
endmodule
